rs_15_9_encoder: RTL and testbench

- Systematic RS(15,9) encoder over GF(16), primitive polynomial x^4+x+1, alpha = 4'b0010.
- Sits directly upstream of the RS(15,9) decoder. It turns a 36-bit message into the 60-bit codeword that the decoder consumes; the decoder computes syndromes S1..S6 at alpha^1..alpha^6.
- Parity is computed by a sequential LFSR, one symbol per clock, with valid/ready handshakes on both sides.

---
 rtl/rs_15_9_encoder.sv | 114 +++++++++++
 tb/tb_rs_15_9_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_15_9_encoder.sv
// Systematic RS(15,9) encoder over GF(16), g(x) = prod(x + alpha^i), i = 1..6.
// Parity is built by a one-symbol-per-clock LFSR, highest-degree message symbol first.
module rs_15_9_encoder #(
  parameter int SYM_W = 4,
  parameter int N     = 15,
  parameter int K     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [K*SYM_W-1:0]   msgIn,
  input  logic                 msgValid,
  output logic                 msgReady,
  output logic [N*SYM_W-1:0]   codeOut,
  output logic                 codeValid,
  input  logic                 codeReady,
  output logic                 busy
);

  localparam int P = N - K;

  // Generator coefficients g0..g5; the monic x^6 term is implicit in the LFSR shift.
  localparam logic [SYM_W-1:0] genPoly [P] = '{4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7};

  typedef enum logic [1:0] {IDLE, ENCODE, DONE} EncState;

  EncState state, nextState;

  logic [K*SYM_W-1:0] msgReg;
  logic [SYM_W-1:0]   par     [P];
  logic [SYM_W-1:0]   parNext [P];
  logic [P*SYM_W-1:0] parFlat;
  logic [3:0]         symCnt;
  logic [3:0]         symIdx;
  logic [SYM_W-1:0]   curSym;
  logic [SYM_W-1:0]   fb;
  logic               lastSym;

  // Constant-coefficient GF(16) multiply, reducing by x^4 + x + 1 after each shift.
  function automatic logic [SYM_W-1:0] gfMul(input logic [SYM_W-1:0] a,
                                             input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? SYM_W'(4'h3) : '0);
    end
    return acc;
  endfunction

  always_comb begin
    symIdx  = 4'(K - 1) - symCnt;
    curSym  = msgReg[{symIdx, 2'b00} +: SYM_W];
    fb      = curSym ^ par[P-1];
    lastSym = (symCnt == 4'(K - 1));
    parNext[0] = gfMul(genPoly[0], fb);
    for (int i = 1; i < P; i++) begin
      parNext[i] = par[i-1] ^ gfMul(genPoly[i], fb);
    end
    parFlat = '0;
    for (int i = 0; i < P; i++) begin
      parFlat[i*SYM_W +: SYM_W] = parNext[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (msgValid)  nextState = ENCODE;
      ENCODE:  if (lastSym)   nextState = DONE;
      DONE:    if (codeReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    msgReady  = !rst && (state == IDLE);
    busy      = !rst && (state != IDLE);
    codeValid = (state == DONE);
  end

  // The final ENCODE edge loads codeOut from parNext, so parity lands without an extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      msgReg  <= '0;
      symCnt  <= '0;
      codeOut <= '0;
      for (int i = 0; i < P; i++) par[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (msgValid) begin
            msgReg <= msgIn;
            symCnt <= '0;
            for (int i = 0; i < P; i++) par[i] <= '0;
          end
        end
        ENCODE: begin
          par    <= parNext;
          symCnt <= symCnt + 4'd1;
          if (lastSym) codeOut <= {msgReg, parFlat};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_15_9_encoder.sv
// Randomized bench for rs_15_9_encoder: long-division reference encoder, syndrome
// evaluation and a Peterson-style decoder that corrects up to three symbol errors.
module tb_rs_15_9_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] msgIn;
  logic        msgValid;
  logic        msgReady;
  logic [59:0] codeOut;
  logic        codeValid;
  logic        codeReady;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] alphaPow [15];
  int         logTab   [16];
  logic [3:0] genFull  [7];
  logic [3:0] mat      [3][4];
  logic [3:0] sol      [3];
  int         errPos   [3];

  rs_15_9_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .msgIn     (msgIn),
    .msgValid  (msgValid),
    .msgReady  (msgReady),
    .codeOut   (codeOut),
    .codeValid (codeValid),
    .codeReady (codeReady),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Field tables from repeated multiplication by x modulo x^4 + x + 1.
  task automatic buildTables();
    logic [4:0] t;
    logic [3:0] tmp [7];
    t = 5'd1;
    for (int e = 0; e < 15; e++) begin
      alphaPow[e]  = t[3:0];
      logTab[t[3:0]] = e;
      t = {t[3:0], 1'b0};
      if (t[4]) t = t ^ 5'b10011;
    end
    logTab[0] = 0;
    for (int k = 0; k < 7; k++) genFull[k] = 4'd0;
    genFull[0] = 4'd1;
    for (int r = 1; r <= 6; r++) begin
      tmp = genFull;
      for (int k = 0; k < 7; k++)
        genFull[k] = gMul(tmp[k], alphaPow[r]) ^ ((k > 0) ? tmp[k-1] : 4'd0);
    end
  endtask

  function automatic logic [3:0] gMul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'd0 || b == 4'd0) return 4'd0;
    return alphaPow[(logTab[a] + logTab[b]) % 15];
  endfunction

  function automatic logic [3:0] gPow(input int e);
    return alphaPow[((e % 15) + 15) % 15];
  endfunction

  function automatic logic [3:0] gInv(input logic [3:0] a);
    return alphaPow[(15 - logTab[a]) % 15];
  endfunction

  // Remainder of x^6*m(x) divided by g(x), by ordinary polynomial long division.
  function automatic logic [59:0] modelEncode(input logic [35:0] msg);
    logic [3:0]  d [15];
    logic [3:0]  q;
    logic [59:0] code;
    for (int i = 0; i < 15; i++) d[i] = 4'd0;
    for (int i = 0; i < 9; i++) d[i+6] = msg[4*i +: 4];
    for (int deg = 14; deg >= 6; deg--) begin
      q = d[deg];
      for (int k = 0; k < 7; k++) d[deg-6+k] = d[deg-6+k] ^ gMul(q, genFull[k]);
    end
    code = '0;
    code[59:24] = msg;
    for (int i = 0; i < 6; i++) code[4*i +: 4] = d[i];
    return code;
  endfunction

  function automatic logic [3:0] syndrome(input logic [59:0] w, input int j);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 15; i++) s = s ^ gMul(w[4*i +: 4], gPow(i * j));
    return s;
  endfunction

  task automatic solveSys(input int n, output bit ok);
    int         p;
    logic [3:0] f;
    logic [3:0] inv;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      p = -1;
      for (int r = c; r < n; r++) if (p < 0 && mat[r][c] != 4'd0) p = r;
      if (p < 0) begin
        ok = 1'b0;
        return;
      end
      for (int k = 0; k <= n; k++) begin
        f = mat[c][k]; mat[c][k] = mat[p][k]; mat[p][k] = f;
      end
      inv = gInv(mat[c][c]);
      for (int k = 0; k <= n; k++) mat[c][k] = gMul(mat[c][k], inv);
      for (int r = 0; r < n; r++) begin
        if (r != c) begin
          f = mat[r][c];
          for (int k = 0; k <= n; k++) mat[r][k] = mat[r][k] ^ gMul(f, mat[c][k]);
        end
      end
    end
    for (int r = 0; r < n; r++) sol[r] = mat[r][n];
  endtask

  task automatic decodeWord(input logic [59:0] rx, output logic [35:0] msgOut);
    logic [3:0]  synd [7];
    logic [3:0]  lam  [4];
    logic [3:0]  val;
    logic [59:0] fixedWord;
    int          nRoots;
    bit          ok;
    bit          done;
    bit          anyErr;
    fixedWord = rx;
    anyErr    = 1'b0;
    done      = 1'b0;
    synd[0]   = 4'd0;
    for (int j = 1; j <= 6; j++) begin
      synd[j] = syndrome(rx, j);
      if (synd[j] != 4'd0) anyErr = 1'b1;
    end
    if (anyErr) begin
      for (int nu = 3; nu >= 1 && !done; nu--) begin
        for (int a = 0; a < nu; a++) begin
          for (int b = 0; b < nu; b++) mat[a][b] = synd[a+b+1];
          mat[a][nu] = synd[a+nu+1];
        end
        solveSys(nu, ok);
        if (ok) begin
          lam[0] = 4'd1;
          for (int k = 1; k <= nu; k++) lam[k] = sol[nu-k];
          nRoots = 0;
          for (int i = 0; i < 15; i++) begin
            val = lam[0];
            for (int k = 1; k <= nu; k++) val = val ^ gMul(lam[k], gPow(-i * k));
            if (val == 4'd0) begin
              if (nRoots < 3) errPos[nRoots] = i;
              nRoots++;
            end
          end
          if (nRoots == nu) begin
            for (int j = 1; j <= nu; j++) begin
              for (int c = 0; c < nu; c++) mat[j-1][c] = gPow(errPos[c] * j);
              mat[j-1][nu] = synd[j];
            end
            solveSys(nu, ok);
            if (ok) begin
              for (int c = 0; c < nu; c++)
                fixedWord[4*errPos[c] +: 4] = fixedWord[4*errPos[c] +: 4] ^ sol[c];
              done = 1'b1;
            end
          end
        end
      end
    end
    msgOut = fixedWord[59:24];
  endtask

  // One full transaction; msgIn is scrambled right after acceptance to show it is not re-sampled.
  task automatic applyStimulus(input logic [35:0] msg, input int readyDelay,
                               output logic [59:0] code, output int latency);
    @(negedge clk);
    msgIn    = msg;
    msgValid = 1'b1;
    @(negedge clk);
    msgValid = 1'b0;
    msgIn    = {4'($urandom), $urandom};
    latency  = 0;
    while (!codeValid && latency < 30) begin
      @(negedge clk);
      latency++;
    end
    code = codeOut;
    repeat (readyDelay) @(negedge clk);
    codeReady = 1'b1;
    @(negedge clk);
    codeReady = 1'b0;
  endtask

  initial begin
    logic [59:0] code;
    logic [59:0] expCode;
    logic [59:0] corrupted;
    logic [35:0] msg;
    logic [35:0] decoded;
    logic [3:0]  syndOr;
    logic [14:0] usedMask;
    int          lat;
    int          nErr;
    int          placed;
    int          p;

    buildTables();
    rst       = 1'b1;
    msgValid  = 1'b0;
    codeReady = 1'b0;
    msgIn     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstMsgReady",  64'(msgReady),  64'd0);
    checkOutput("rstBusy",      64'(busy),      64'd0);
    checkOutput("rstCodeValid", 64'(codeValid), 64'd0);
    checkOutput("rstCodeOut",   64'(codeOut),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleMsgReady",  64'(msgReady),  64'd1);
    checkOutput("idleBusy",      64'(busy),      64'd0);
    checkOutput("idleCodeValid", 64'(codeValid), 64'd0);

    applyStimulus(36'h0, 0, code, lat);
    checkOutput("zeroCode",    64'(code), 64'h0);
    checkOutput("zeroLatency", 64'(lat),  64'd9);
    applyStimulus(36'h000000001, 0, code, lat);
    checkOutput("oneCode", 64'(code), 64'h000000001793CAC);
    applyStimulus(36'h000000002, 2, code, lat);
    checkOutput("twoCode",       64'(code),      64'h000000002E16B7B);
    checkOutput("postHsValid",   64'(codeValid), 64'd0);
    checkOutput("postHsReady",   64'(msgReady),  64'd1);
    checkOutput("postHsHoldOut", 64'(codeOut),   64'h000000002E16B7B);

    // Stall in DONE for 20 clocks with a stray message offered midway.
    msg     = 36'h123456789;
    expCode = modelEncode(msg);
    @(negedge clk);
    msgIn    = msg;
    msgValid = 1'b1;
    @(negedge clk);
    msgValid = 1'b0;
    lat      = 0;
    while (!codeValid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("holdLatency", 64'(lat), 64'd9);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        msgIn    = 36'hFEDCBA987;
        msgValid = 1'b1;
      end
      if (c == 7) msgValid = 1'b0;
      @(negedge clk);
      checkOutput("holdValid", 64'(codeValid), 64'd1);
      checkOutput("holdCode",  64'(codeOut),   64'(expCode));
      checkOutput("holdReady", 64'(msgReady),  64'd0);
    end
    codeReady = 1'b1;
    @(negedge clk);
    codeReady = 1'b0;
    checkOutput("releaseValid", 64'(codeValid), 64'd0);
    checkOutput("releaseReady", 64'(msgReady),  64'd1);
    @(negedge clk);
    checkOutput("strayIgnored", 64'(busy), 64'd0);

    // Reset lands on the fifth processing edge.
    @(negedge clk);
    msgIn    = 36'h000000001;
    msgValid = 1'b1;
    @(negedge clk);
    msgValid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstReady",     64'(msgReady),  64'd0);
    checkOutput("midRstBusy",      64'(busy),      64'd0);
    checkOutput("midRstCodeValid", 64'(codeValid), 64'd0);
    checkOutput("midRstCodeOut",   64'(codeOut),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("afterRstReady", 64'(msgReady), 64'd1);
    checkOutput("afterRstBusy",  64'(busy),     64'd0);
    applyStimulus(36'h000000001, 0, code, lat);
    checkOutput("afterRstCode", 64'(code), 64'h000000001793CAC);

    for (int n = 0; n < 200; n++) begin
      msg = {4'($urandom), $urandom};
      applyStimulus(msg, $urandom_range(0, 3), code, lat);
      checkOutput("randLatency", 64'(lat),  64'd9);
      checkOutput("randCode",    64'(code), 64'(modelEncode(msg)));
      syndOr = 4'd0;
      for (int j = 1; j <= 6; j++) syndOr = syndOr | syndrome(code, j);
      checkOutput("randSyndrome", 64'(syndOr), 64'd0);
      decodeWord(code, decoded);
      checkOutput("randDecodeClean", 64'(decoded), 64'(msg));
      corrupted = code;
      usedMask  = '0;
      nErr      = $urandom_range(1, 3);
      placed    = 0;
      while (placed < nErr) begin
        p = $urandom_range(0, 14);
        if (!usedMask[p]) begin
          usedMask[p] = 1'b1;
          corrupted[4*p +: 4] = corrupted[4*p +: 4] ^ 4'($urandom_range(1, 15));
          placed++;
        end
      end
      decodeWord(corrupted, decoded);
      checkOutput("randDecodeErr", 64'(decoded), 64'(msg));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
